// File: rtl/shifter_ctrl8_pkg.sv
// Shared constants and types for the multi-cycle 8-bit shifter controller.
package shifter_ctrl8_pkg;

  localparam int unsigned W = 8;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Shifts saturate at the word width; rotates wrap modulo the width.
  function automatic logic [3:0] eff_amount(input op_e op, input logic [5:0] shamt);
    if (op == OP_ROR) begin
      return {1'b0, shamt[2:0]};
    end else if (shamt > 6'd8) begin
      return 4'd8;
    end else begin
      return shamt[3:0];
    end
  endfunction

endpackage

// File: rtl/shifter_ctrl8_stage.sv
// One combinational shift step of 0..3 bit positions, one 4:1 mux per output bit.
module mx4 (
  input  logic [3:0] in_i,
  input  logic [1:0] sel_i,
  output logic       out_o
);
  assign out_o = in_i[sel_i];
endmodule

module shift_stage8
  import shifter_ctrl8_pkg::*;
(
  input  logic [W-1:0] data_i,
  input  op_e          op_i,
  input  logic [1:0]   amt_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0]   shifted [4];
  logic [2*W-1:0] rot;

  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rot = {data_i, data_i} >> k;
      case (op_i)
        OP_LSL:  shifted[k] = data_i << k;
        OP_LSR:  shifted[k] = data_i >> k;
        OP_ASR:  shifted[k] = $signed(data_i) >>> k;
        default: shifted[k] = rot[W-1:0];
      endcase
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    mx4 u_mx4 (
      .in_i  ({shifted[3][i], shifted[2][i], shifted[1][i], shifted[0][i]}),
      .sel_i (amt_i),
      .out_o (data_o[i])
    );
  end

endmodule

// File: rtl/shifter_ctrl8.sv
// Multi-cycle shifter: accepts a request in IDLE, shifts up to 3 bits per RUN cycle
// through a single time-shared stage, and presents the result with a one-cycle done.
module shifter_ctrl8
  import shifter_ctrl8_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] d_in,
  input  logic [5:0]   shamt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d_out
);

  state_e       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  op_e          op_q, op_d;
  logic [3:0]   rem_q, rem_d;
  logic [W-1:0] dout_q, dout_d;
  logic [1:0]   step;
  logic [W-1:0] stage_out;

  assign step = (rem_q > 4'd3) ? 2'd3 : rem_q[1:0];

  shift_stage8 u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .amt_i  (step),
    .data_o (stage_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = d_in;
          op_d    = op_e'(op);
          rem_d   = eff_amount(op_e'(op), shamt);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A zero amount still spends one RUN cycle with a step of 0.
        data_d = stage_out;
        rem_d  = rem_q - {2'b00, step};
        if (rem_q <= 4'd3) begin
          dout_d  = stage_out;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= OP_LSL;
      rem_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign d_out = dout_q;

endmodule

// File: tb/tb_shifter_ctrl8.sv
// Scoreboard bench for shifter_ctrl8: stimulus pushes expected results and timing,
// a negedge monitor checks busy, done timing and d_out against them every cycle.
module tb_shifter_ctrl8;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] op;
  logic [7:0] d_in;
  logic [5:0] shamt;
  logic       busy, done;
  logic [7:0] d_out;

  shifter_ctrl8 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .d_in  (d_in),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         i;    // cycle in which start was presented
    int         n;    // number of RUN cycles
    logic [7:0] res;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         free_cyc = 0;
  logic [7:0] exp_dout = 8'h00;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic int eff_of(input int o, input int s);
    if (o == 3) return s % 8;
    return (s > 8) ? 8 : s;
  endfunction

  function automatic int runs_of(input int e);
    return (e == 0) ? 1 : (e + 2) / 3;
  endfunction

  function automatic logic [7:0] model(input int o, input int d, input int s);
    int e = eff_of(o, s);
    int v;
    case (o)
      0: v = (d << e) & 255;
      1: v = d >> e;
      2: begin
        v = (d >= 128) ? d - 256 : d;
        v = (v >>> e) & 255;
      end
      default: v = ((d >> e) | (d << (8 - e))) & 255;
    endcase
    return v[7:0];
  endfunction

  // forced >= 0 supplies a hand-derived result instead of the model's.
  task automatic issue(input int o, input int d, input int s, input bit keep, input int forced);
    exp_t e;
    while (cyc < free_cyc) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    op    = o[1:0];
    d_in  = d[7:0];
    shamt = s[5:0];
    e.i   = cyc;
    e.n   = runs_of(eff_of(o, s));
    e.res = (forced >= 0) ? forced[7:0] : model(o, d, s);
    q.push_back(e);
    free_cyc = cyc + e.n + 2;
    @(posedge clk); #1;
    if (!keep) begin
      start = 1'b0;
      op    = 2'($urandom);
      d_in  = 8'($urandom);
      shamt = 6'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy;
      exp_busy = (q.size() > 0) && (cyc > q[0].i) && (cyc <= q[0].i + q[0].n);
      chk("busy", int'(busy), int'(exp_busy));
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("done_cycle", cyc, q[0].i + q[0].n + 1);
          chk("result", int'(d_out), int'(q[0].res));
          exp_dout = q[0].res;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc > q[0].i + q[0].n + 1) begin
        chk("missing_done", 0, 1);
        void'(q.pop_front());
      end
      chk("dout_hold", int'(d_out), int'(exp_dout));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    d_in  = 8'h5A;
    shamt = 6'd1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dout", int'(d_out), 0);
    start = 1'b0;
    reset = 1'b0;
    free_cyc = cyc;
    mon_en = 1'b1;

    issue(0, 8'h01, 7, 1'b0, 8'h80);
    issue(2, 8'h90, 40, 1'b0, 8'hFF);
    issue(1, 8'h90, 40, 1'b0, 8'h00);
    issue(3, 8'hA5, 9, 1'b0, 8'hD2);
    issue(3, 8'hA5, 8, 1'b0, 8'hA5);

    // Start pulse while the first operation is in RUN must be ignored.
    issue(0, 8'h01, 7, 1'b0, 8'h80);
    start = 1'b1;
    d_in  = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;

    // Reset during the second RUN cycle aborts with no done pulse.
    issue(0, 8'h03, 6, 1'b0, 8'hC0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    exp_dout = 8'h00;
    free_cyc = cyc;
    issue(0, 8'h03, 6, 1'b0, 8'hC0);

    // start held high: a new accept on every IDLE cycle after DONE.
    for (int k = 0; k < 6; k++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 63)), (k != 5), -1);
    end

    for (int k = 0; k < 40; k++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 63)), 1'b0, -1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    if (q.size() != 0) chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
